// File: rtl/regfile_wb_arbiter.sv
// Two-source round-robin writeback arbiter in front of a register-file write port.
// Grants are combinational; the selected write is registered and appears one cycle later.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_hold,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            grant_id,
  output logic [7:0]      conflict_cnt
);

  logic [1:0]      valid;
  logic [1:0]      grant;
  logic            last_grant;
  logic            transfer;
  logic            win_id;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  assign valid = {req1_valid, req0_valid};

  // A requester wins when it is alone, or on a tie when it was not the last winner.
  // Reset level gates the grants so nothing is accepted while reset is asserted.
  assign grant[0] = rst & ~rf_hold & valid[0] & (~valid[1] | last_grant);
  assign grant[1] = rst & ~rf_hold & valid[1] & (~valid[0] | ~last_grant);

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign transfer = |grant;
  assign win_id   = grant[1];
  assign win_rd   = grant[1] ? req1_rd   : req0_rd;
  assign win_data = grant[1] ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we        <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
      grant_id     <= 1'b0;
      last_grant   <= 1'b1;
      conflict_cnt <= 8'd0;
    end else begin
      // Writes to x0 are accepted upstream but never reach the register file.
      rf_we <= transfer && (win_rd != '0);
      if (transfer) begin
        rf_rd      <= win_rd;
        rf_wdata   <= win_data;
        grant_id   <= win_id;
        last_grant <= win_id;
      end
      if ((&valid) && (conflict_cnt != 8'hFF)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of the register-file write port.
REQ-002 Parameter AW, default 5, register index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 = reset asserted.
REQ-005 rf_hold  input  1  1 = block all grants this cycle, e.g. during pipeline flush.
REQ-006 req0_valid  input  1  execute-stage writeback request.
REQ-007 req0_rd  input  AW  destination register of req0.
REQ-008 req0_data  input  XLEN  write data of req0.
REQ-009 req0_ready  output  1  req0 accepted this cycle, combinational.
REQ-010 req1_valid / req1_rd / req1_data / req1_ready: same as REQ-006..009, for the load/memory writeback source.
REQ-011 rf_we  output  1  register-file write enable (RegWr), registered.
REQ-012 rf_rd  output  AW  register-file write index (Rw), registered.
REQ-013 rf_wdata  output  XLEN  register-file write data (busW), registered.
REQ-014 grant_id  output  1  source of the most recent accepted request, registered.
REQ-015 conflict_cnt  output  8  saturating count of cycles in which both requesters were valid.

Function
REQ-016 Transfer on reqN = reqN_valid & reqN_ready on the same cycle; data/rd SHALL be sampled only on transfer.
REQ-017 rf_hold=1 SHALL force req0_ready=req1_ready=0, regardless of valid.
REQ-018 One valid, rf_hold=0: that requester SHALL be granted (ready=1) the same cycle.
REQ-019 Both valid, rf_hold=0: exactly one SHALL be granted, the one not equal to last_grant (round-robin).
REQ-020 reqN_ready SHALL never be 1 while reqN_valid=0.
REQ-021 last_grant SHALL update to the granted index only on a transfer; unchanged otherwise, including under rf_hold.
REQ-022 Latency: a transfer in cycle T SHALL produce rf_rd/rf_wdata/grant_id of that request in cycle T+1.
REQ-023 rf_we in T+1 SHALL be 1 iff a transfer occurred in T and its rd != 0; writes to x0 are accepted and silently dropped.
REQ-024 No transfer in T: rf_we=0 in T+1; rf_rd, rf_wdata, grant_id SHALL hold their previous values.
REQ-025 Same rd from both sources in one cycle: normal round-robin; the loser SHALL be written in a later cycle, so the loser's data lands last.
REQ-026 A valid request not granted SHALL be assumed held stable by its source; the arbiter holds no copy of it.
REQ-027 conflict_cnt SHALL increment by 1 each cycle req0_valid & req1_valid=1 (rf_hold ignored), saturating at 255, never wrapping.
REQ-028 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-029 rst=0 SHALL immediately (asynchronously) force rf_we=0, rf_rd=0, rf_wdata=0, grant_id=0, conflict_cnt=0, last_grant=1.
REQ-030 During reset req0_ready=req1_ready=0.
REQ-031 Reset asserted mid-transfer SHALL cancel the pending write: no rf_we pulse after rst returns to 1.
REQ-032 First tie after reset SHALL be granted to req0.

Verification
REQ-033 After reset, both valid (req0 rd=3 data=0xAAAA0001, req1 rd=4 data=0xBBBB0002) held 2 cycles -> cycle1 req0_ready=1; cycle2 rf_we=1, rf_rd=3, rf_wdata=0xAAAA0001, req1_ready=1; cycle3 rf_rd=4, rf_wdata=0xBBBB0002, grant_id=1.
REQ-034 req1 only, rd=0, data=0x12345678 -> req1_ready=1; next cycle rf_we=0, grant_id=1.
REQ-035 rf_hold=1 with both valid for 3 cycles -> readies 0, rf_we 0, conflict_cnt=3, last_grant unchanged; release -> grant per round-robin.
REQ-036 Both valid 300 consecutive cycles -> conflict_cnt=255 and stays 255; grants alternate 0,1,0,1.
REQ-037 Transfer req0 rd=5 in cycle T, rst=0 asserted mid-cycle T+1 -> rf_we=0 immediately, all outputs 0, no write of rd=5 after release.
